// File: rtl/rw_manager_ac_store.sv
`default_nettype none
// ============================================================================
//  Module      : rw_manager_ac_store
//  Description : Writable address/command instruction store for the DDR3
//                read/write manager sequencer. Registered address, registered
//                data read path (result two edges after the request), a patch
//                write port, ready handshakes on both ports, a one-cycle
//                read-valid pulse, zero data for out-of-range reads, and an
//                init FSM that fills every word with INIT_VALUE after reset
//                or on request.
//  Ports       : clock, reset_n (async, active low)
//                init_start / init_busy          : re-init request / status
//                rd_en, rd_addr, rd_ready        : read request handshake
//                q, q_valid                      : read result, 1-cycle pulse
//                wr_en, wr_addr, wr_data, wr_ready : write request handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module rw_manager_ac_store #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 6,
   parameter int                    DEPTH      = 40,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  init_start,
   output logic                  init_busy,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] q,
   output logic                  q_valid,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_ready
);

   localparam logic [ADDR_WIDTH-1:0] c_last  = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   c_depth = (ADDR_WIDTH + 1)'(DEPTH);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } state_t;

   state_t                  r_state;
   logic [ADDR_WIDTH-1:0]   r_init_cnt;
   logic [ADDR_WIDTH-1:0]   r_rd_addr;
   logic                    r_rd_vld;
   logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

   logic                    w_rd_acc;
   logic                    w_wr_acc;
   logic                    w_rd_in_range;
   logic                    w_we;
   logic [ADDR_WIDTH-1:0]   w_waddr;
   logic [DATA_WIDTH-1:0]   w_wdata;

   // Ready outputs are registered copies of the state, so they are always
   // consistent with r_state on the same cycle.
   assign w_rd_acc      = rd_en & rd_ready;
   assign w_wr_acc      = wr_en & wr_ready & ({1'b0, wr_addr} < c_depth);
   assign w_rd_in_range = ({1'b0, r_rd_addr} < c_depth);

   // Single shared write port. The user port is never ready during INIT,
   // so the init fill owns the port whenever it is active.
   assign w_we    = (r_state == ST_INIT) | w_wr_acc;
   assign w_waddr = (r_state == ST_INIT) ? r_init_cnt : wr_addr;
   assign w_wdata = (r_state == ST_INIT) ? INIT_VALUE : wr_data;

   // ------------------------------------------------------------------------
   // Init / idle state machine with registered status outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_INIT;
         r_init_cnt <= '0;
         init_busy  <= 1'b1;
         rd_ready   <= 1'b0;
         wr_ready   <= 1'b0;
      end else begin
         case (r_state)
            ST_INIT: begin
               if (r_init_cnt == c_last) begin
                  r_state    <= ST_IDLE;
                  r_init_cnt <= '0;
                  init_busy  <= 1'b0;
                  rd_ready   <= 1'b1;
                  wr_ready   <= 1'b1;
               end else begin
                  r_init_cnt <= r_init_cnt + ADDR_WIDTH'(1);
               end
            end
            ST_IDLE: begin
               if (init_start) begin
                  r_state    <= ST_INIT;
                  r_init_cnt <= '0;
                  init_busy  <= 1'b1;
                  rd_ready   <= 1'b0;
                  wr_ready   <= 1'b0;
               end
            end
            default: begin
               r_state    <= ST_INIT;
               r_init_cnt <= '0;
               init_busy  <= 1'b1;
               rd_ready   <= 1'b0;
               wr_ready   <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Storage array: no reset, contents defined by the init pass
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (w_we) begin
         r_mem[w_waddr] <= w_wdata;
      end
   end

   // ------------------------------------------------------------------------
   // Read pipeline: address registered on accept, array read one edge later.
   // Reading on the edge after accept gives read-before-write against a
   // write landing on that same edge.
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_addr <= '0;
         r_rd_vld  <= 1'b0;
         q         <= '0;
         q_valid   <= 1'b0;
      end else begin
         r_rd_vld <= w_rd_acc;
         if (w_rd_acc) begin
            r_rd_addr <= rd_addr;
         end
         q_valid <= r_rd_vld;
         if (r_rd_vld) begin
            q <= w_rd_in_range ? r_mem[r_rd_addr] : '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/rw_manager_ac_store.md
Name: rw_manager_ac_store

Overview:
- Parametrised, writable successor to the fixed address/command instruction ROM in the DDR3 read/write manager.
- Holds the AC instruction words that the rw_manager sequencer fetches.
- Keeps the 2-edge registered-address/registered-data read timing.
- Adds: runtime patch (write) port, read/write ready handshakes, a 1-cycle read-valid pulse, out-of-range read masking, and an init state machine that fills every word with INIT_VALUE after reset or on request.

Parameters:
DATA_WIDTH, 32, instruction word width
ADDR_WIDTH, 6, address width of both ports
DEPTH, 40, number of implemented words; 1 <= DEPTH <= 2**ADDR_WIDTH
INIT_VALUE, 0, word written to every location during init

Ports:
clock  input  1  single clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
init_start  input  1  in IDLE, pulse starts a re-init
init_busy  output  1  high while the init FSM is filling memory
rd_en  input  1  read request
rd_addr  input  ADDR_WIDTH  read address
rd_ready  output  1  read request accepted when rd_en & rd_ready
q  output  DATA_WIDTH  read data
q_valid  output  1  1-cycle pulse, q carries a new read result
wr_en  input  1  write request
wr_addr  input  ADDR_WIDTH  write address
wr_data  input  DATA_WIDTH  write data
wr_ready  output  1  write request accepted when wr_en & wr_ready

Behaviour:
- One clock domain; reset is asynchronous and active-low; one clock, no other clock domains.
- Reset values:
  - q=0, q_valid=0, read pipeline valid bits=0.
  - init_busy=1, rd_ready=0, wr_ready=0.
  - FSM=INIT, init counter=0.
- Array contents are not reset; the INIT pass defines them.
- FSM states: INIT, IDLE.
  - INIT:
    - Each cycle writes INIT_VALUE at the counter address, then increments the counter.
    - After writing address DEPTH-1 -> IDLE at the next edge.
    - Total INIT duration is exactly DEPTH cycles.
  - IDLE:
    - init_start=1 -> INIT with counter=0 at the next edge.
    - init_start is ignored in INIT; it does not restart the count.
- Outputs derived from state:
  - init_busy = (state==INIT).
  - rd_ready = wr_ready = (state==IDLE).
  - All three are registered outputs.
- Reset asserted at any time, including mid-INIT: the pass restarts from address 0 after release.
- Read timing:
  - Read accepted at edge N: rd_addr is registered at N.
  - The array is read at N+1; q is loaded and q_valid=1 at N+1 (two edges after presentation, same as the legacy ROM).
  - q_valid deasserts the following cycle unless another read was accepted.
  - q holds its last value between reads.
  - Back-to-back reads give one result per cycle.
- Out-of-range read: a registered address >= DEPTH returns q=0 with q_valid=1.
- Write accepted at edge N: array[wr_addr] <= wr_data at N.
  - Out-of-range write addresses (>= DEPTH) are dropped silently.
- Read/write ordering:
  - A read sees every write accepted at or before its own accept edge.
  - A write accepted exactly one edge after the read's accept edge is not visible to that read (read-before-write on the shared edge).
- Read and write to the same or different addresses may be accepted on the same edge.
- Entering INIT:
  - Reads already accepted drain normally and deliver pre-init data.
  - No new reads or writes are accepted until IDLE.
  - Requests held high simply wait.
- Array is inferred block RAM: 1 write port (shared between init and wr port, init has priority by construction) and 1 registered read port.

Test Plan:
- Release reset with DEPTH=40 -> init_busy=1 for exactly 40 cycles, then rd_ready=wr_ready=1; reads of 0x00, 0x15, 0x27 return 0 with q_valid pulsing 2 edges after each request.
- Write 0x180E0000@0x00, 0x0C010211@0x02, 0x0C0F0000@0x23; read back 0x02, 0x00, 0x23 on consecutive cycles -> q=0x0C010211, 0x180E0000, 0x0C0F0000 on 3 consecutive cycles, q_valid high for all 3.
- Read 0x27 and write 0x0C090000@0x27 on the same edge -> q=0x0C090000. Read 0x27 one edge before a write of 0x11111111 -> old value returned.
- Read 0x28 and 0x3F -> q=0, q_valid=1. Write 0xDEADBEEF@0x30 -> no effect; a full sweep of 0x00..0x27 is unchanged.
- In IDLE, pulse init_start with 2 reads in flight -> both reads return pre-init data; init_busy=1 for 40 cycles; afterwards all 40 words read 0. An init_start pulse mid-INIT does not extend the pass.
- Assert reset_n=0 at init cycle 20 and while q_valid=1 -> q=0 and q_valid=0 immediately; after release a full 40-cycle INIT runs.
